// File: rtl/tmds_pkg.sv
// Shared constants, encodings and PRBS helper for the TMDS lane gearbox.
// Holds the blank token, clock-lane words, test-mode codes and PRBS7 seed.
package tmds_pkg;

    localparam logic [9:0] TMDS_BLANK_TOKEN = 10'b1101010100;
    localparam logic [4:0] CLK_WORD_HI      = 5'b11111;
    localparam logic [4:0] CLK_WORD_LO      = 5'b00000;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_BLANK  = 2'd1;
    localparam logic [1:0] MODE_PRBS   = 2'd2;
    localparam logic [1:0] MODE_FIXED  = 2'd3;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } gb_state_e;

    // x^7+x^6+1, five steps; returns {next_state, bits} with the
    // first generated bit in bit 0.
    function automatic logic [11:0] prbs7_step5(input logic [6:0] s);
        logic [6:0] st;
        logic [4:0] b;
        logic       nb;
        st = s;
        b  = '0;
        for (int i = 0; i < 5; i++) begin
            nb   = st[6] ^ st[5];
            st   = {st[5:0], nb};
            b[i] = nb;
        end
        return {st, b};
    endfunction

endpackage

// File: rtl/tmds_sym_fifo.sv
// Shallow symbol FIFO between the pixel source and the gearbox.
// Ports: push/pop/din in; dout (head), full, empty, level out.
module tmds_sym_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic                     pclkx2,
    input  logic                     serdes_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    always_ff @(posedge pclkx2) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge pclkx2 or posedge serdes_rst) begin
        if (serdes_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + (AW+1)'(1);
            else if (pop && !push) level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/tmds_lane_gearbox.sv
// Splits 10-bit TMDS symbols into 5-bit halves for the 5:1 serialisers,
// and generates the clock-lane word. Inputs: sym_wr/sym_in (FIFO push),
// mode/fixed_sym (test modes), clr_flags. Outputs: lane_out,
// clk_lane_out, half_phase, running, sticky underflow/overflow, level.
module tmds_lane_gearbox
    import tmds_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DEPTH       = 4,
    parameter int START_LEVEL = 2
) (
    input  logic                     pclkx2,
    input  logic                     serdes_rst,
    input  logic                     sym_wr,
    input  logic [NUM_CH*10-1:0]     sym_in,
    input  logic [1:0]               mode,
    input  logic [9:0]               fixed_sym,
    input  logic                     clr_flags,
    output logic [NUM_CH*5-1:0]      lane_out,
    output logic [4:0]               clk_lane_out,
    output logic                     half_phase,
    output logic                     running,
    output logic                     underflow,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] START_LW = LW'(START_LEVEL);

    gb_state_e state_q;
    gb_state_e state_d;

    logic                    phase;
    logic                    boundary;
    logic [1:0]              mode_q;
    logic [1:0]              cur_mode;
    logic [NUM_CH*10-1:0]    head;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    uf_ev;
    logic                    of_ev;
    logic [NUM_CH*10-1:0]    sym_sel;
    logic [NUM_CH*5-1:0]     sym_lo;
    logic [NUM_CH*5-1:0]     sym_hi;
    logic [NUM_CH*5-1:0]     hold_q;
    logic [NUM_CH-1:0][6:0]  prbs_q;
    logic [NUM_CH-1:0][6:0]  prbs_nxt;
    logic [NUM_CH-1:0][4:0]  prbs_bits;

    assign boundary = ~phase;
    assign running  = (state_q == ST_RUN);
    // mode only takes effect at pixel boundaries; mid-pixel uses the latch.
    assign cur_mode = boundary ? mode : mode_q;

    assign pop   = boundary & running & ~empty;
    assign uf_ev = boundary & running & empty;
    assign push  = sym_wr & (~full | pop);
    assign of_ev = sym_wr & full & ~pop;

    tmds_sym_fifo #(
        .WIDTH (NUM_CH*10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .pclkx2     (pclkx2),
        .serdes_rst (serdes_rst),
        .push       (push),
        .pop        (pop),
        .din        (sym_in),
        .dout       (head),
        .full       (full),
        .empty      (empty),
        .level      (level)
    );

    always_ff @(posedge pclkx2 or posedge serdes_rst) begin
        if (serdes_rst) state_q <= ST_PRIME;
        else            state_q <= state_d;
    end

    // Entering RUN never pops on the same boundary.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_PRIME && boundary && level >= START_LW) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        sym_sel = {NUM_CH{TMDS_BLANK_TOKEN}};
        unique case (1'b1)
            (mode == MODE_NORMAL): sym_sel = pop ? head
                                       : {NUM_CH{TMDS_BLANK_TOKEN}};
            (mode == MODE_FIXED):  sym_sel = {NUM_CH{fixed_sym}};
            default:               sym_sel = {NUM_CH{TMDS_BLANK_TOKEN}};
        endcase
    end

    always_comb begin
        sym_lo = '0;
        sym_hi = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sym_lo[5*k +: 5] = sym_sel[10*k +: 5];
            sym_hi[5*k +: 5] = sym_sel[10*k+5 +: 5];
        end
    end

    always_comb begin
        prbs_nxt  = prbs_q;
        prbs_bits = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            {prbs_nxt[k], prbs_bits[k]} = prbs7_step5(prbs_q[k]);
        end
    end

    always_ff @(posedge pclkx2 or posedge serdes_rst) begin
        if (serdes_rst) begin
            phase        <= 1'b0;
            half_phase   <= 1'b0;
            clk_lane_out <= CLK_WORD_LO;
            lane_out     <= '0;
            hold_q       <= '0;
            mode_q       <= MODE_NORMAL;
            for (int k = 0; k < NUM_CH; k++) begin
                prbs_q[k] <= PRBS7_SEED;
            end
        end else begin
            phase        <= ~phase;
            half_phase   <= phase;
            clk_lane_out <= boundary ? CLK_WORD_HI : CLK_WORD_LO;
            if (boundary) mode_q <= mode;
            // PRBS runs a fresh 5-bit word every cycle, not per pixel.
            if (cur_mode == MODE_PRBS) begin
                lane_out <= prbs_bits;
                prbs_q   <= prbs_nxt;
            end else if (boundary) begin
                lane_out <= sym_lo;
                hold_q   <= sym_hi;
            end else begin
                lane_out <= hold_q;
            end
        end
    end

    // Set events override a simultaneous clear.
    always_ff @(posedge pclkx2 or posedge serdes_rst) begin
        if (serdes_rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (uf_ev)          underflow <= 1'b1;
            else if (clr_flags) underflow <= 1'b0;
            if (of_ev)          overflow  <= 1'b1;
            else if (clr_flags) overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmds_lane_gearbox.sv
// Scoreboard bench for tmds_lane_gearbox: stimulus pushes the expected
// outputs for each edge, a monitor pops and compares after that edge.
module tb_tmds_lane_gearbox;

    logic        pclkx2 = 1'b0;
    logic        serdes_rst;
    logic        sym_wr;
    logic [29:0] sym_in;
    logic [1:0]  mode;
    logic [9:0]  fixed_sym;
    logic        clr_flags;
    logic [14:0] lane_out;
    logic [4:0]  clk_lane_out;
    logic        half_phase;
    logic        running;
    logic        underflow;
    logic        overflow;
    logic [2:0]  level;

    tmds_lane_gearbox #(
        .NUM_CH      (3),
        .DEPTH       (4),
        .START_LEVEL (2)
    ) dut (
        .pclkx2       (pclkx2),
        .serdes_rst   (serdes_rst),
        .sym_wr       (sym_wr),
        .sym_in       (sym_in),
        .mode         (mode),
        .fixed_sym    (fixed_sym),
        .clr_flags    (clr_flags),
        .lane_out     (lane_out),
        .clk_lane_out (clk_lane_out),
        .half_phase   (half_phase),
        .running      (running),
        .underflow    (underflow),
        .overflow     (overflow),
        .level        (level)
    );

    always #5 pclkx2 = ~pclkx2;

    typedef struct {
        string       nm;
        logic [26:0] e;
        logic [26:0] m;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [26:0] ALL = '1;
    localparam logic [14:0] BLO = {3{5'b10100}};
    localparam logic [14:0] BHI = {3{5'b11010}};
    localparam logic [14:0] FLO = {3{5'b01010}};
    localparam logic [14:0] FHI = {3{5'b10101}};

    logic [26:0] obs;
    assign obs = {lane_out, clk_lane_out, half_phase, running,
                  underflow, overflow, level};

    task automatic chk(input string nm, input logic [26:0] got,
                       input logic [26:0] e, input logic [26:0] m);
        checks++;
        if ((got & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s: got lanes=%b clk=%b hp=%b run=%b uf=%b of=%b lvl=%0d, expected lanes=%b clk=%b hp=%b run=%b uf=%b of=%b lvl=%0d",
                     nm, got[26:12], got[11:7], got[6], got[5], got[4],
                     got[3], got[2:0], e[26:12], e[11:7], e[6], e[5],
                     e[4], e[3], e[2:0]);
        end
    endtask

    function automatic logic [29:0] pk(input logic [9:0] s);
        return {s, ~s, s};
    endfunction

    function automatic logic [14:0] lo3(input logic [29:0] w);
        return {w[24:20], w[14:10], w[4:0]};
    endfunction

    function automatic logic [14:0] hi3(input logic [29:0] w);
        return {w[29:25], w[19:15], w[9:5]};
    endfunction

    // b = 1 for a pixel-boundary edge: clock word high, low half shown.
    function automatic logic [26:0] ex(input logic b, input logic [14:0] l,
                                       input logic run, input logic uf,
                                       input logic of, input logic [2:0] lv);
        return {l, b ? 5'b11111 : 5'b00000, ~b, run, uf, of, lv};
    endfunction

    task automatic cyc(input logic wr, input logic [9:0] s,
                       input logic [1:0] md, input logic clr,
                       input string nm, input logic [26:0] e,
                       input logic [26:0] m);
        @(negedge pclkx2);
        sym_wr    = wr;
        sym_in    = pk(s);
        mode      = md;
        clr_flags = clr;
        sb.push_back('{nm, e, m});
    endtask

    always @(posedge pclkx2) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.nm, obs, x.e, x.m);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    logic [9:0]  s_tab [8];
    logic [2:0]  lv_tab [18];
    logic [14:0] l_exp;
    logic [6:0]  pr_s;
    logic [4:0]  pr_w;
    logic        pr_nb;

    initial begin
        s_tab  = '{10'h0A5, 10'h15A, 10'h2F0, 10'h10F,
                   10'h333, 10'h0CC, 10'h3C3, 10'h3FF};
        lv_tab = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3,
                   3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        serdes_rst = 1'b1;
        sym_wr     = 1'b0;
        sym_in     = '0;
        mode       = 2'd0;
        fixed_sym  = 10'h2AA;
        clr_flags  = 1'b0;
        #12;
        chk("rst_init", obs, '0, ALL);
        @(posedge pclkx2);
        #2 serdes_rst = 1'b0;

        cyc(0, 0, 0, 0, "idle_e0", ex(1, BLO, 0, 0, 0, 0), ALL);
        cyc(0, 0, 0, 0, "idle_e1", ex(0, BHI, 0, 0, 0, 0), ALL);
        cyc(0, 0, 0, 0, "idle_e2", ex(1, BLO, 0, 0, 0, 0), ALL);
        cyc(0, 0, 0, 0, "idle_e3", ex(0, BHI, 0, 0, 0, 0), ALL);

        cyc(1, 10'h3A5, 0, 0, "prime_w1", ex(1, BLO, 0, 0, 0, 1), ALL);
        cyc(1, 10'h15A, 0, 0, "prime_w2", ex(0, BHI, 0, 0, 0, 2), ALL);
        cyc(0, 0, 0, 0, "enter_run", ex(1, BLO, 1, 0, 0, 2), ALL);
        cyc(0, 0, 0, 0, "run_blank", ex(0, BHI, 1, 0, 0, 2), ALL);
        cyc(0, 0, 0, 0, "sym1_lo",
            ex(1, lo3(pk(10'h3A5)), 1, 0, 0, 1), ALL);
        cyc(0, 0, 0, 0, "sym1_hi",
            ex(0, hi3(pk(10'h3A5)), 1, 0, 0, 1), ALL);
        cyc(0, 0, 0, 0, "sym2_lo",
            ex(1, lo3(pk(10'h15A)), 1, 0, 0, 0), ALL);
        cyc(0, 0, 0, 0, "sym2_hi",
            ex(0, hi3(pk(10'h15A)), 1, 0, 0, 0), ALL);

        cyc(0, 0, 0, 0, "uf_set", ex(1, BLO, 1, 1, 0, 0), ALL);
        cyc(0, 0, 0, 0, "uf_hold", ex(0, BHI, 1, 1, 0, 0), ALL);
        cyc(0, 0, 0, 1, "uf_clr_collide", ex(1, BLO, 1, 1, 0, 0), ALL);
        cyc(0, 0, 0, 1, "uf_clr", ex(0, BHI, 1, 0, 0, 0), ALL);
        cyc(0, 0, 0, 0, "uf_reset", ex(1, BLO, 1, 1, 0, 0), ALL);
        cyc(0, 0, 0, 1, "uf_clr2", ex(0, BHI, 1, 0, 0, 0), ALL);

        for (int i = 0; i < 18; i++) begin
            if (i >= 2 && i < 16)
                l_exp = (i % 2 == 0) ? lo3(pk(s_tab[(i-2)/2]))
                                     : hi3(pk(s_tab[(i-2)/2]));
            else
                l_exp = (i % 2 == 0) ? BLO : BHI;
            cyc(i < 8, (i < 8) ? s_tab[i] : 10'h000, 0, i == 17,
                $sformatf("fill_%0d", i),
                ex(i % 2 == 0, l_exp, 1, i < 17, i >= 7 && i < 17,
                   lv_tab[i]), ALL);
        end

        cyc(0, 0, 3, 0, "fixed_lo", ex(1, FLO, 1, 1, 0, 0), ALL);
        cyc(0, 0, 3, 0, "fixed_hi", ex(0, FHI, 1, 1, 0, 0), ALL);
        cyc(0, 0, 3, 0, "fixed_lo2", ex(1, FLO, 1, 1, 0, 0), ALL);
        cyc(0, 0, 1, 0, "mode_mid", ex(0, FHI, 1, 1, 0, 0), ALL);
        cyc(1, 10'h1F0, 1, 0, "blank_mode",
            ex(1, BLO, 1, 1, 0, 1), ALL);

        @(negedge pclkx2);
        serdes_rst = 1'b1;
        sym_wr     = 1'b0;
        mode       = 2'd2;
        #1;
        chk("rst_mid", obs, '0, ALL);
        repeat (2) @(posedge pclkx2);
        #2 serdes_rst = 1'b0;

        pr_s = 7'h7F;
        for (int c = 0; c < 130; c++) begin
            for (int b = 0; b < 5; b++) begin
                pr_nb   = pr_s[6] ^ pr_s[5];
                pr_s    = {pr_s[5:0], pr_nb};
                pr_w[b] = pr_nb;
            end
            cyc(0, 0, 2, 0, $sformatf("prbs_%0d", c),
                ex(c % 2 == 0, {3{pr_w}}, 0, 0, 0, 0), ALL);
        end

        repeat (2) @(negedge pclkx2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
